// File: rtl/dmem_port_arbiter_if.sv
// Data-memory sharing bundle between the core load/store path, the debug
// port and the data memory itself.
//
// Handshake: the debug side holds dbg_valid and its addr/we/wdata/lock stable
// until it sees dbg_ready high in the same cycle; the transfer happens on the
// rising edge where dbg_valid && dbg_ready. Read data comes back one edge
// later as a single-cycle dbg_rvalid pulse with dbg_rdata. The CPU side has no
// ready: cpu_stall tells the core to hold its PC and regfile write instead.
interface dmem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;

   logic              dbg_valid;
   logic              dbg_we;
   logic              dbg_lock;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_ready;
   logic              dbg_rvalid;
   logic [DATA_W-1:0] dbg_rdata;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wd;
   logic [DATA_W-1:0] mem_rd;

   // Arbiter side
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  dbg_valid, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
      output dbg_ready, dbg_rvalid, dbg_rdata,
      output mem_we, mem_addr, mem_wd,
      input  mem_rd
   );

   // Core / debug host / memory side
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output dbg_valid, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
      input  dbg_ready, dbg_rvalid, dbg_rdata,
      input  mem_we, mem_addr, mem_wd,
      output mem_rd
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: one-grant-per-cycle arbiter sharing the data memory
// between the CPU load/store path and a debug/loader port. A pending debug
// request may lose to the CPU at most MAX_WAIT (1..15) consecutive cycles
// before it is forced through; dbg_lock keeps debug ownership across a burst.
// Optional build macro DMEM_ARB_STATS_EN adds saturating stall_cnt and
// dbg_xfer_cnt counters.
module dmem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   dmem_port_arbiter_if.slave  bus,
   output logic                state_dbg,
   output logic [3:0]          wait_cnt_dbg
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]         stall_cnt,
   output logic [15:0]         dbg_xfer_cnt
`endif
);

   typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

   localparam logic [3:0] MAX_W4 = 4'(MAX_WAIT);

   state_t            state_q, state_d;
   logic [3:0]        wait_cnt_q, wait_cnt_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              dbg_gnt;
   logic              dbg_xfer;
   logic [ADDR_W-1:0] mux_addr;
   logic [DATA_W-1:0] mux_wd;
   logic              mux_we;

   // Grant decision: lock owns the memory, otherwise an idle CPU or an
   // exhausted wait budget hands it to the debug port.
   always_comb begin
      dbg_gnt  = (state_q == LOCKED) ||
                 (bus.dbg_valid && (!bus.cpu_req || wait_cnt_q == MAX_W4));
      dbg_xfer = dbg_gnt && bus.dbg_valid;
   end

   // Memory port mux follows the grant.
   always_comb begin
      if (dbg_gnt) begin
         mux_we   = bus.dbg_valid && bus.dbg_we;
         mux_addr = bus.dbg_addr;
         mux_wd   = bus.dbg_wdata;
      end else begin
         mux_we   = bus.cpu_req && bus.cpu_we;
         mux_addr = bus.cpu_addr;
         mux_wd   = bus.cpu_wdata;
      end
   end

   assign bus.mem_we     = mux_we;
   assign bus.mem_addr   = mux_addr;
   assign bus.mem_wd     = mux_wd;
   assign bus.cpu_rdata  = bus.mem_rd;
   assign bus.cpu_stall  = bus.cpu_req && dbg_gnt;
   assign bus.dbg_ready  = dbg_xfer;
   assign bus.dbg_rvalid = rvalid_q;
   assign bus.dbg_rdata  = rdata_q;
   assign state_dbg      = state_q;
   assign wait_cnt_dbg   = wait_cnt_q;

   // Next-state: lock transitions, wait budget and debug read capture.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      rvalid_d   = 1'b0;
      rdata_d    = rdata_q;

      case (state_q)
         ARB: if (dbg_xfer && bus.dbg_lock) state_d = LOCKED;
         LOCKED: begin
            // Lock is released by the last beat or by an idle unlocked cycle.
            if ((dbg_xfer && !bus.dbg_lock) || (!bus.dbg_valid && !bus.dbg_lock))
               state_d = ARB;
         end
         default: state_d = ARB;
      endcase

      if (dbg_xfer || !bus.dbg_valid || state_q == LOCKED)
         wait_cnt_d = 4'd0;
      else if (wait_cnt_q < MAX_W4)
         wait_cnt_d = wait_cnt_q + 4'd1;

      if (dbg_xfer && !bus.dbg_we) begin
         rvalid_d = 1'b1;
         rdata_d  = bus.mem_rd;
      end
   end

   // FSM and registered debug read outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ARB;
         wait_cnt_q <= 4'd0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
      end
   end

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] xfer_cnt_q, xfer_cnt_d;

   // Saturating statistics counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      xfer_cnt_d  = xfer_cnt_q;
      if (bus.cpu_stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      if (dbg_xfer && xfer_cnt_q != 16'hFFFF)       xfer_cnt_d  = xfer_cnt_q + 16'd1;
   end

   // Statistics registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 16'd0;
         xfer_cnt_q  <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         xfer_cnt_q  <= xfer_cnt_d;
      end
   end

   assign stall_cnt    = stall_cnt_q;
   assign dbg_xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small word-addressed memory
// model standing in for the data memory.
module tb_dmem_port_arbiter;

   logic clk;
   logic rst;
   logic       state_dbg;
   logic [3:0] wait_cnt_dbg;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0] stall_cnt;
   logic [15:0] dbg_xfer_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mem [0:63];

   dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .state_dbg    (state_dbg),
      .wait_cnt_dbg (wait_cnt_dbg)
`ifdef DMEM_ARB_STATS_EN
      ,
      .stall_cnt    (stall_cnt),
      .dbg_xfer_cnt (dbg_xfer_cnt)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model: combinational read, write on rising edge
   assign bus.mem_rd = mem[bus.mem_addr[7:2]];
   always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wd;

   // watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // advance to 1 ns after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_drive(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
      bus.cpu_req   = req;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
   endtask

   task automatic dbg_drive(input logic valid, input logic we, input logic lock,
                            input logic [31:0] addr, input logic [31:0] wdata);
      bus.dbg_valid = valid;
      bus.dbg_we    = we;
      bus.dbg_lock  = lock;
      bus.dbg_addr  = addr;
      bus.dbg_wdata = wdata;
   endtask

   // CPU loads continuously while a debug write waits: 4 losses, then forced
   task automatic forced_window(input logic [31:0] addr, input logic [31:0] data);
      cpu_drive(1'b1, 1'b0, 32'd100, 32'd0);
      dbg_drive(1'b1, 1'b1, 1'b0, addr, data);
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("fw_ready_low%0d", i), {31'd0, bus.dbg_ready}, 32'd0);
         check($sformatf("fw_no_stall%0d", i), {31'd0, bus.cpu_stall}, 32'd0);
         check($sformatf("fw_wait%0d", i), {28'd0, wait_cnt_dbg}, i);
         tick();
      end
      #1;
      check("fw_ready_forced", {31'd0, bus.dbg_ready}, 32'd1);
      check("fw_stall_forced", {31'd0, bus.cpu_stall}, 32'd1);
      check("fw_mem_addr", bus.mem_addr, addr);
      check("fw_mem_we", {31'd0, bus.mem_we}, 32'd1);
      tick();
      dbg_drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      rst = 1'b1;
      cpu_drive(1'b0, 1'b0, 32'd0, 32'd0);
      dbg_drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (2) @(posedge clk);
      #3;
      // reset state
      check("rst_state", {31'd0, state_dbg}, 32'd0);
      check("rst_wait", {28'd0, wait_cnt_dbg}, 32'd0);
      check("rst_rvalid", {31'd0, bus.dbg_rvalid}, 32'd0);
      check("rst_rdata", bus.dbg_rdata, 32'd0);
      check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      tick();
      rst = 1'b0;

      // CPU only: sw 30 to 100, then lw 100
      cpu_drive(1'b1, 1'b1, 32'd100, 32'd30);
      #1;
      check("cpu_sw_we", {31'd0, bus.mem_we}, 32'd1);
      check("cpu_sw_addr", bus.mem_addr, 32'd100);
      check("cpu_sw_wd", bus.mem_wd, 32'd30);
      check("cpu_sw_stall", {31'd0, bus.cpu_stall}, 32'd0);
      tick();
      cpu_drive(1'b1, 1'b0, 32'd100, 32'd0);
      #1;
      check("cpu_lw_we", {31'd0, bus.mem_we}, 32'd0);
      check("cpu_lw_rdata", bus.cpu_rdata, 32'd30);
      check("cpu_lw_stall", {31'd0, bus.cpu_stall}, 32'd0);
      tick();
      cpu_drive(1'b0, 1'b0, 32'd0, 32'd0);

      // idle CPU, debug write then read of 0x40
      dbg_drive(1'b1, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
      #1;
      check("dbg_wr_ready", {31'd0, bus.dbg_ready}, 32'd1);
      check("dbg_wr_we", {31'd0, bus.mem_we}, 32'd1);
      check("dbg_wr_addr", bus.mem_addr, 32'h40);
      tick();
      dbg_drive(1'b1, 1'b0, 1'b0, 32'h40, 32'd0);
      #1;
      check("dbg_rd_ready", {31'd0, bus.dbg_ready}, 32'd1);
      check("dbg_rd_we", {31'd0, bus.mem_we}, 32'd0);
      check("dbg_rd_rvalid_early", {31'd0, bus.dbg_rvalid}, 32'd0);
      exp_q.push_back(32'hDEADBEEF);
      tick();
      dbg_drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      check("dbg_rvalid", {31'd0, bus.dbg_rvalid}, 32'd1);
      if (exp_q.size() > 0) check("dbg_rdata", bus.dbg_rdata, exp_q.pop_front());
      tick();
      check("dbg_rvalid_drop", {31'd0, bus.dbg_rvalid}, 32'd0);
      check("dbg_rdata_hold", bus.dbg_rdata, 32'hDEADBEEF);

      // forced grant under continuous CPU traffic
      forced_window(32'h44, 32'h1234_5678);
      #1;
      check("fw_wait_clear", {28'd0, wait_cnt_dbg}, 32'd0);
      check("fw_after_stall", {31'd0, bus.cpu_stall}, 32'd0);
      tick();

      // locked burst to 0x0, 0x4, 0x8 with an idle locked gap
      cpu_drive(1'b1, 1'b0, 32'd100, 32'd0);
      dbg_drive(1'b1, 1'b1, 1'b1, 32'h0, 32'hA0A0_0000);
      for (int i = 0; i < 4; i++) tick();
      #1;
      check("lk_b0_ready", {31'd0, bus.dbg_ready}, 32'd1);
      check("lk_b0_stall", {31'd0, bus.cpu_stall}, 32'd1);
      tick();
      check("lk_state", {31'd0, state_dbg}, 32'd1);
      dbg_drive(1'b1, 1'b1, 1'b1, 32'h4, 32'hA0A0_0004);
      #1;
      check("lk_b1_ready", {31'd0, bus.dbg_ready}, 32'd1);
      check("lk_b1_stall", {31'd0, bus.cpu_stall}, 32'd1);
      tick();
      dbg_drive(1'b0, 1'b0, 1'b1, 32'h0, 32'd0);
      #1;
      check("lk_gap_stall", {31'd0, bus.cpu_stall}, 32'd1);
      check("lk_gap_we", {31'd0, bus.mem_we}, 32'd0);
      tick();
      check("lk_gap_state", {31'd0, state_dbg}, 32'd1);
      dbg_drive(1'b1, 1'b1, 1'b0, 32'h8, 32'hA0A0_0008);
      #1;
      check("lk_b2_ready", {31'd0, bus.dbg_ready}, 32'd1);
      check("lk_b2_stall", {31'd0, bus.cpu_stall}, 32'd1);
      tick();
      dbg_drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      check("lk_end_state", {31'd0, state_dbg}, 32'd0);
      check("lk_end_stall", {31'd0, bus.cpu_stall}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         cpu_drive(1'b1, 1'b0, 32'(i * 4), 32'd0);
         #1;
         check($sformatf("lk_mem%0d", i), bus.cpu_rdata, 32'hA0A0_0000 + 32'(i * 4));
      end
      tick();

      // reset during LOCKED with a read in flight
      cpu_drive(1'b0, 1'b0, 32'd0, 32'd0);
      dbg_drive(1'b1, 1'b0, 1'b1, 32'h40, 32'd0);
      #1;
      check("rl_ready", {31'd0, bus.dbg_ready}, 32'd1);
      tick();
      check("rl_locked", {31'd0, state_dbg}, 32'd1);
      check("rl_rvalid", {31'd0, bus.dbg_rvalid}, 32'd1);
      rst = 1'b1;
      #1;
      check("rl_state_arb", {31'd0, state_dbg}, 32'd0);
      check("rl_rvalid_drop", {31'd0, bus.dbg_rvalid}, 32'd0);
      check("rl_rdata_clr", bus.dbg_rdata, 32'd0);
      dbg_drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      cpu_drive(1'b1, 1'b0, 32'd100, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("rl_no_stall", {31'd0, bus.cpu_stall}, 32'd0);
      check("rl_cpu_data", bus.cpu_rdata, 32'd30);

`ifdef DMEM_ARB_STATS_EN
      // statistics over two forced-grant windows from a clean reset
      rst = 1'b1;
      #1;
      check("st_rst_stall", {16'd0, stall_cnt}, 32'd0);
      check("st_rst_xfer", {16'd0, dbg_xfer_cnt}, 32'd0);
      tick();
      rst = 1'b0;
      forced_window(32'h48, 32'h1);
      forced_window(32'h4C, 32'h2);
      cpu_drive(1'b0, 1'b0, 32'd0, 32'd0);
      tick();
      check("st_stall_cnt", {16'd0, stall_cnt}, 32'd2);
      check("st_xfer_cnt", {16'd0, dbg_xfer_cnt}, 32'd2);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
